rhs_result_fifo: RTL and testbench

//   Downstream stage for the rhs_converter_case results: buffers 8-bit result words, each with a
//   1-bit select tag (ctrl_sel), in a small register-memory FIFO with valid/ready on both sides.

---
 rtl/rhs_result_fifo.sv | 137 +++++++++++++
 tb/tb_rhs_result_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rhs_result_fifo.sv
// rhs_result_fifo
//   Result buffer behind the rhs converter. It holds DATA_WIDTH-bit result words, each with a
//   1-bit select tag, in a small register-memory FIFO. Both sides use a valid/ready handshake.
//   The read port is first-word-fall-through: the head word is presented as soon as it is stored.
//   The block also reports the current occupancy and the highest occupancy seen since reset.
//
// Parameters
//   DATA_WIDTH  width of each result word
//   DEPTH       number of entries; must be a power of two and at least 2
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   producer has a word
//   in_ready   out  FIFO can accept a word (not full)
//   in_data    in   result word
//   in_tag     in   select tag
//   out_valid  out  FIFO holds a word (not empty)
//   out_ready  in   consumer takes the head word
//   out_data   out  head word; 0 when empty
//   out_tag    out  head tag; 0 when empty
//   count      out  current occupancy, 0..DEPTH
//   peak       out  maximum occupancy since reset
//   checksum   out  rotate-xor checksum of popped words; present only with
//                   RHS_RESULT_FIFO_CHECKSUM_EN defined
//
// Build option
//   RHS_RESULT_FIFO_CHECKSUM_EN  adds the checksum output and its update logic.

module rhs_result_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_tag,
  output logic [$clog2(DEPTH):0]     count,
`ifdef RHS_RESULT_FIFO_CHECKSUM_EN
  output logic [$clog2(DEPTH):0]     peak,
  output logic [DATA_WIDTH-1:0]      checksum
`else
  output logic [$clog2(DEPTH):0]     peak
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic                  tag;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t mem [DEPTH];

  // The extra MSB on each pointer distinguishes full from empty when the indices match.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [PW-1:0] next_count;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // No bypass: an empty FIFO presents zeros even while a push is in flight.
  assign out_data = empty ? '0   : mem[rd_idx].data;
  assign out_tag  = empty ? 1'b0 : mem[rd_idx].tag;

  always_comb begin
    next_count = count;
    if (push && !pop) begin
      next_count = count + PW'(1);
    end else if (pop && !push) begin
      next_count = count - PW'(1);
    end
  end

  // Storage is not reset; a push in the reset cycle is blocked so nothing is written then.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_idx] <= '{tag: in_tag, data: in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      peak   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= next_count;
      if (next_count > peak) begin
        peak <= next_count;
      end
    end
  end

`ifdef RHS_RESULT_FIFO_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= {checksum[DATA_WIDTH-2:0], checksum[DATA_WIDTH-1]} ^ out_data;
    end
  end
`endif

endmodule

// File: tb/tb_rhs_result_fifo.sv
module tb_rhs_result_fifo;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_tag;
  logic [2:0] count;
  logic [2:0] peak;
`ifdef RHS_RESULT_FIFO_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  rhs_result_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .count     (count),
`ifdef RHS_RESULT_FIFO_CHECKSUM_EN
    .peak      (peak),
    .checksum  (checksum)
`else
    .peak      (peak)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge, where inputs also change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d, input logic t);
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000 ns");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_tag    = 1'b0;
    out_ready = 1'b0;

    // Reset
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count",     count,     0);
    check("rst_peak",      peak,      0);
    check("rst_out_data",  out_data,  8'h00);
    check("rst_out_tag",   out_tag,   0);
`ifdef RHS_RESULT_FIFO_CHECKSUM_EN
    check("rst_checksum",  checksum,  8'h00);
`endif

    // Single push, visible next cycle
    push_word(8'hAA, 1'b1);
    check("p1_out_valid", out_valid, 1);
    check("p1_out_data",  out_data,  8'hAA);
    check("p1_out_tag",   out_tag,   1);
    check("p1_count",     count,     1);
    check("p1_peak",      peak,      1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("p1_pop_valid", out_valid, 0);
    check("p1_pop_data",  out_data,  8'h00);
    check("p1_pop_tag",   out_tag,   0);
    check("p1_pop_count", count,     0);
    check("p1_pop_peak",  peak,      1);

    // Fill to full, overflow attempt, full with same-cycle pop
    for (int i = 1; i <= 4; i++) begin
      push_word(8'(i), i[0]);
    end
    check("full_count",    count,    4);
    check("full_in_ready", in_ready, 0);
    check("full_peak",     peak,     4);
    in_valid = 1'b1;
    in_data  = 8'h05;
    in_tag   = 1'b1;
    tick();
    check("ovf_count", count, 4);
    check("ovf_head",  out_data, 8'h01);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("fullpop_count",    count,    3);
    check("fullpop_in_ready", in_ready, 1);
    for (int i = 2; i <= 4; i++) begin
      check($sformatf("drain_data_%0d", i), out_data, i);
      check($sformatf("drain_tag_%0d", i),  out_tag,  i % 2);
      tick();
    end
    out_ready = 1'b0;
    check("drain_count", count,     0);
    check("drain_valid", out_valid, 0);

    // Steady push+pop at occupancy 2 across pointer wrap
    push_word(8'h10, 1'b0);
    push_word(8'h11, 1'b1);
    check("steady_pre_count", count, 2);
    for (int k = 0; k < 6; k++) begin
      in_valid  = 1'b1;
      in_data   = 8'(8'h12 + k);
      in_tag    = k[0];
      out_ready = 1'b1;
      check($sformatf("steady_head_%0d", k), out_data, 8'h10 + k);
      tick();
      check($sformatf("steady_count_%0d", k), count, 2);
    end
    in_valid = 1'b0;
    check("steady_tail0", out_data, 8'h16);
    tick();
    check("steady_tail1", out_data, 8'h17);
    tick();
    out_ready = 1'b0;
    check("steady_empty", out_valid, 0);
    check("steady_peak",  peak,      4);

    // Reset mid-operation with a push in the reset cycle
    push_word(8'hA1, 1'b0);
    push_word(8'hA2, 1'b0);
    push_word(8'hA3, 1'b0);
    check("mid_count", count, 3);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("mrst_count",    count,     0);
    check("mrst_valid",    out_valid, 0);
    check("mrst_peak",     peak,      0);
    check("mrst_in_ready", in_ready,  1);
    check("mrst_data",     out_data,  8'h00);
    tick();
    check("mrst_lost_count", count,     0);
    check("mrst_lost_valid", out_valid, 0);
    push_word(8'h5A, 1'b1);
    check("post_rst_data",  out_data, 8'h5A);
    check("post_rst_count", count,    1);
    check("post_rst_peak",  peak,     1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

`ifdef RHS_RESULT_FIFO_CHECKSUM_EN
    // Checksum: clear, then pop 80 and 01
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("cks_clear", checksum, 8'h00);
    push_word(8'h80, 1'b0);
    push_word(8'h01, 1'b0);
    out_ready = 1'b1;
    tick();
    check("cks_first", checksum, 8'h80);
    tick();
    out_ready = 1'b0;
    check("cks_second", checksum, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
